matmul_seq_ctrl: RTL and testbench
==================================

# matmul_seq_ctrl

Sequencer for the systolic-array matrix multiplier. It sits behind the register file, which is fed by the APB slave. On a start pulse it latches the operand dimensions and raises busy, so the register file rejects APB writes. It then steps the datapath through clear, operand feed, drain and result write-back, and emits a one-cycle done pulse.

## Interface
Parameters:
- DATA_WIDTH, 8, operand element width (8/16/32)
- BUS_WIDTH, 32, bus/row width (16/32/64)
- ADDR_WIDTH, 16, APB address width (16/24/32)
- SP_NTARGETS, 2, scratchpad result targets (1/2/4)
- MAX_DIM (localparam), BUS_WIDTH/DATA_WIDTH, maximum matrix dimension
- DW (localparam), $clog2(MAX_DIM), dimension field width
- TW (localparam), max(1,$clog2(SP_NTARGETS)), target field width

Ports. Clock is clk_i; reset is rst_ni, synchronous, active-low:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  start pulse from register file control write
- dim_k_i / dim_m_i / dim_n_i  in  DW each  dimension minus 1 (K inner, M rows of A, N cols of B)
- target_i  in  TW  scratchpad target for result
- busy_o  out  1  operation in progress; to register file / APB busy
- done_o  out  1  one-cycle completion pulse
- array_clr_o  out  1  clear array accumulators
- rd_en_o  out  1  operand read strobe to register file
- op_idx_o  out  DW  operand index k (column of A, row of B)
- feed_valid_o  out  1  operand data valid at array input (rd_en_o delayed 1)
- res_we_o  out  1  result row write strobe
- res_row_o  out  DW  result row index
- res_target_o  out  TW  latched target

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, WB, DONE. BIAS is added only with the macro.
- IDLE: on start_i=1, latch K=dim_k_i+1, M=dim_m_i+1, N=dim_n_i+1 and target_i, then go to CLEAR.
- CLEAR: 1 cycle, array_clr_o=1, then go to FEED.
- FEED: K cycles, rd_en_o=1, op_idx_o counts 0..K-1, then go to DRAIN.
- DRAIN: M+N cycles. This covers the last feed_valid cycle plus skew propagation. Then go to WB.
- WB: M cycles, res_we_o=1, res_row_o counts 0..M-1, res_target_o=latched target. Then go to DONE.
- DONE: 1 cycle, done_o=1, then go to IDLE.
- busy_o=1 in every state except IDLE.
- feed_valid_o is registered: it equals rd_en_o from the previous cycle, and its index matches the op_idx_o of that cycle.
- start_i while busy is ignored. Latched dimensions and target do not change mid-operation.
- Dimension inputs are sampled only on the accepted start edge. Changes at any other time have no effect.
- Counters count in DW+1-bit arithmetic, so M+N=2*MAX_DIM does not overflow. The step counter never wraps, because each state reloads it on entry.
- Reset mid-operation: on the next edge, state returns to IDLE and all outputs go to 0. There is no partial write-back.
- Reset value of every output: 0.

## Timing
- Cycle 0 is the start_i sample edge, in IDLE.
- CLEAR occupies cycle 1.
- FEED occupies cycles 2..K+1; feed_valid_o is high in cycles 3..K+2.
- DRAIN occupies cycles K+2..K+M+N+1.
- WB occupies cycles K+M+N+2..K+2M+N+1.
- done_o is high at cycle K+2M+N+2.
- busy_o is high from cycle 1 through the done cycle, inclusive.
- A new start is accepted on the cycle after DONE, which is the first IDLE cycle.
- Minimum latency, K=M=N=1: done at cycle 6.

## Configuration
- Macro: MATMUL_SEQ_CTRL_BIAS_EN.
- Defined:
  - Adds input bias_en_i (1) and outputs bias_ld_o (1) and bias_row_o (DW).
  - bias_en_i is latched with start.
  - If the latched value is 1, a BIAS state of M cycles is inserted between CLEAR and FEED. In it, bias_ld_o=1 and bias_row_o counts 0..M-1, preloading the accumulators from the target. All later timing shifts by M.
  - If the latched value is 0, timing is identical to the undefined case.
- Undefined: no BIAS state and no extra ports; accumulators start from the CLEAR value of zero.

## Structure
- Shared package matmul_pkg holds:
  - the state encoding constants;
  - MAX_DIM and dimension/target width derivations;
  - the default parameter values.
- One natural sub-module, matmul_step_cnt: a loadable down-counter with a terminal-count flag and an up-index output. It is reused for the FEED/DRAIN/WB/BIAS durations.

## Test plan
- Reset: rst_ni low for 2 cycles with start_i=1. All outputs stay 0 and the FSM stays in IDLE.
- 4x4x4 with MAX_DIM=4 (dims=3,3,3, target=1):
  - rd_en_o in cycles 2..5 with op_idx_o 0..3; feed_valid_o in cycles 3..6.
  - res_we_o in cycles 14..17 with rows 0..3 and res_target_o=1.
  - done_o at cycle 18; busy_o over cycles 1..18.
- 1x1x1 (dims=0): array_clr_o at cycle 1, rd_en_o at cycle 2, res_we_o at cycle 5, done_o at cycle 6.
- start_i pulsed at cycle 5 of a 4x4x4 run with different dims: ignored, and done_o still at cycle 18.
- Reset asserted during FEED: all outputs are 0 on the next edge, and no res_we_o follows. A new start afterwards completes normally.
- With MATMUL_SEQ_CTRL_BIAS_EN and bias_en_i=1 on 2x2x2: bias_ld_o in cycles 2..3 with rows 0..1, FEED in cycles 4..5, done_o at cycle 12.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul sequencer: default parameters, width
// derivations and the sequencer state encoding.
package matmul_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int BUS_WIDTH_DEF   = 32;
  localparam int ADDR_WIDTH_DEF  = 16;
  localparam int SP_NTARGETS_DEF = 2;

  function automatic int calc_max_dim(input int bus_w, input int data_w);
    return bus_w / data_w;
  endfunction

  function automatic int calc_dw(input int max_dim);
    return $clog2(max_dim);
  endfunction

  function automatic int calc_tw(input int ntargets);
    return (ntargets > 1) ? $clog2(ntargets) : 1;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_BIAS  = 3'd2,
    S_FEED  = 3'd3,
    S_DRAIN = 3'd4,
    S_WB    = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Control/datapath bundle between register file and matmul sequencer.
// MATMUL_SEQ_CTRL_BIAS_EN adds the accumulator bias-preload signals.
interface matmul_seq_ctrl_if
  import matmul_pkg::*;
#(
  parameter int DW = calc_dw(calc_max_dim(BUS_WIDTH_DEF, DATA_WIDTH_DEF)),
  parameter int TW = calc_tw(SP_NTARGETS_DEF)
);
  logic          start_i;
  logic [DW-1:0] dim_k_i;
  logic [DW-1:0] dim_m_i;
  logic [DW-1:0] dim_n_i;
  logic [TW-1:0] target_i;
  logic          busy_o;
  logic          done_o;
  logic          array_clr_o;
  logic          rd_en_o;
  logic [DW-1:0] op_idx_o;
  logic          feed_valid_o;
  logic          res_we_o;
  logic [DW-1:0] res_row_o;
  logic [TW-1:0] res_target_o;
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
  logic          bias_en_i;
  logic          bias_ld_o;
  logic [DW-1:0] bias_row_o;
`endif

  modport master (
    output start_i, dim_k_i, dim_m_i, dim_n_i, target_i,
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
    output bias_en_i,
    input  bias_ld_o, bias_row_o,
`endif
    input  busy_o, done_o, array_clr_o, rd_en_o, op_idx_o, feed_valid_o,
    input  res_we_o, res_row_o, res_target_o
  );

  modport slave (
    input  start_i, dim_k_i, dim_m_i, dim_n_i, target_i,
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
    input  bias_en_i,
    output bias_ld_o, bias_row_o,
`endif
    output busy_o, done_o, array_clr_o, rd_en_o, op_idx_o, feed_valid_o,
    output res_we_o, res_row_o, res_target_o
  );

endinterface

// File: rtl/matmul_step_cnt.sv
// Loadable down-counter timing one sequencer phase: terminal-count flag on
// the last cycle and an up-running index from 0.
module matmul_step_cnt #(
  parameter int CW = 3,
  parameter int IW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,  // phase length minus 1
  input  logic          en_i,
  output logic          tc_o,
  output logic [IW-1:0] idx_o
);

  logic [CW-1:0] remain_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      remain_q <= '0;
      idx_q    <= '0;
    end else if (load_i) begin
      remain_q <= load_val_i;
      idx_q    <= '0;
    end else if (en_i && (remain_q != '0)) begin
      remain_q <= remain_q - 1'b1;
      idx_q    <= idx_q + 1'b1;
    end
  end

  assign tc_o  = (remain_q == '0);
  assign idx_o = idx_q;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Systolic matmul sequencer: CLEAR -> FEED -> DRAIN -> WB -> DONE per start.
// MATMUL_SEQ_CTRL_BIAS_EN inserts an optional BIAS preload phase after CLEAR.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int BUS_WIDTH   = BUS_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int SP_NTARGETS = SP_NTARGETS_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  matmul_seq_ctrl_if.slave   bus
);

  localparam int MAX_DIM = calc_max_dim(BUS_WIDTH, DATA_WIDTH);
  localparam int DW      = calc_dw(MAX_DIM);
  localparam int TW      = calc_tw(SP_NTARGETS);
  localparam int CW      = DW + 1;

  if (ADDR_WIDTH < 16 || ADDR_WIDTH > 32 || DW < 1) begin : g_cfg_err
    $error("matmul_seq_ctrl: unsupported parameter combination");
  end

  state_e        state_q, state_d;
  logic [DW-1:0] dim_k_q, dim_m_q, dim_n_q;
  logic [TW-1:0] target_q;
  logic          feed_valid_q;
  logic          cnt_load, cnt_en, cnt_tc;
  logic [CW-1:0] cnt_val;
  logic [DW-1:0] cnt_idx;
  logic [CW-1:0] drain_len_m1;
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
  logic          bias_q;
`endif

  // M+N-1 always fits CW bits even at M=N=MAX_DIM
  assign drain_len_m1 = {1'b0, dim_m_q} + {1'b0, dim_n_q} + 1'b1;

  // NOTE: state and operand registers use non-blocking assignments so every
  // flop samples pre-edge values; the reset here is synchronous by design.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      dim_k_q      <= '0;
      dim_m_q      <= '0;
      dim_n_q      <= '0;
      target_q     <= '0;
      feed_valid_q <= 1'b0;
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
      bias_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      feed_valid_q <= (state_q == S_FEED);
      if (state_q == S_IDLE && bus.start_i) begin
        dim_k_q  <= bus.dim_k_i;
        dim_m_q  <= bus.dim_m_i;
        dim_n_q  <= bus.dim_n_i;
        target_q <= bus.target_i;
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
        bias_q   <= bus.bias_en_i;
`endif
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start_i) state_d = S_CLEAR;
      S_CLEAR: begin
        cnt_load = 1'b1;
        state_d  = S_FEED;
        cnt_val  = {1'b0, dim_k_q};
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
        if (bias_q) begin
          state_d = S_BIAS;
          cnt_val = {1'b0, dim_m_q};
        end
`endif
      end
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
      S_BIAS: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d  = S_FEED;
          cnt_load = 1'b1;
          cnt_val  = {1'b0, dim_k_q};
        end
      end
`endif
      S_FEED: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d  = S_DRAIN;
          cnt_load = 1'b1;
          cnt_val  = drain_len_m1;
        end
      end
      S_DRAIN: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d  = S_WB;
          cnt_load = 1'b1;
          cnt_val  = {1'b0, dim_m_q};
        end
      end
      S_WB: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  matmul_step_cnt #(.CW(CW), .IW(DW)) u_step_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .tc_o       (cnt_tc),
    .idx_o      (cnt_idx)
  );

  // Index outputs are forced to zero outside their phase
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.done_o       = (state_q == S_DONE);
  assign bus.array_clr_o  = (state_q == S_CLEAR);
  assign bus.rd_en_o      = (state_q == S_FEED);
  assign bus.op_idx_o     = (state_q == S_FEED) ? cnt_idx : '0;
  assign bus.feed_valid_o = feed_valid_q;
  assign bus.res_we_o     = (state_q == S_WB);
  assign bus.res_row_o    = (state_q == S_WB) ? cnt_idx : '0;
  assign bus.res_target_o = target_q;
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
  assign bus.bias_ld_o    = (state_q == S_BIAS);
  assign bus.bias_row_o   = (state_q == S_BIAS) ? cnt_idx : '0;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: expected outputs per cycle come
// from the phase-boundary arithmetic of the timing description.
module tb_matmul_seq_ctrl;
  import matmul_pkg::*;

  localparam int DW = calc_dw(calc_max_dim(BUS_WIDTH_DEF, DATA_WIDTH_DEF));
  localparam int TW = calc_tw(SP_NTARGETS_DEF);

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          clr;
    logic          rd;
    logic [DW-1:0] idx;
    logic          fv;
    logic          we;
    logic [DW-1:0] row;
    logic [TW-1:0] tgt;
    logic          bld;
    logic [DW-1:0] brow;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   prev_tgt = 0;

  always #5 clk = ~clk;

  matmul_seq_ctrl_if #(.DW(DW), .TW(TW)) bus ();

  matmul_seq_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_at(input int c, input int k, input int m, input int n,
                                     input int bias, input int tgt, input int ptgt);
    exp_t e;
    int bm, f0, d0, w0, dn, tv;
    e  = '0;
    bm = bias ? m : 0;
    f0 = 2 + bm;
    d0 = f0 + k;
    w0 = d0 + m + n;
    dn = w0 + m;
    tv = (c >= 1) ? tgt : ptgt;
    e.tgt  = tv[TW-1:0];
    e.busy = (c >= 1) && (c <= dn);
    e.done = (c == dn);
    e.clr  = (c == 1);
    if (c >= 2 && c < 2 + bm) begin
      e.bld  = 1'b1;
      e.brow = DW'(c - 2);
    end
    if (c >= f0 && c < d0) begin
      e.rd  = 1'b1;
      e.idx = DW'(c - f0);
    end
    e.fv = (c > f0) && (c <= d0);
    if (c >= w0 && c < dn) begin
      e.we  = 1'b1;
      e.row = DW'(c - w0);
    end
    return e;
  endfunction

  task automatic check_all(input string tag, input int c, input exp_t e);
    string t;
    t = $sformatf("%s c%0d", tag, c);
    check({t, " busy"},  32'(bus.busy_o),       32'(e.busy));
    check({t, " done"},  32'(bus.done_o),       32'(e.done));
    check({t, " clr"},   32'(bus.array_clr_o),  32'(e.clr));
    check({t, " rd_en"}, 32'(bus.rd_en_o),      32'(e.rd));
    check({t, " idx"},   32'(bus.op_idx_o),     32'(e.idx));
    check({t, " fv"},    32'(bus.feed_valid_o), 32'(e.fv));
    check({t, " we"},    32'(bus.res_we_o),     32'(e.we));
    check({t, " row"},   32'(bus.res_row_o),    32'(e.row));
    check({t, " tgt"},   32'(bus.res_target_o), 32'(e.tgt));
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
    check({t, " bld"},   32'(bus.bias_ld_o),    32'(e.bld));
    check({t, " brow"},  32'(bus.bias_row_o),   32'(e.brow));
`endif
  endtask

  // Called at a negedge with the DUT idle; cycle 0 is the next posedge.
  task automatic run_op(input string tag, input int k, input int m, input int n,
                        input int tgt, input int bias, input int restart_at,
                        input int reset_at);
    int   dn, last;
    bit   in_reset;
    exp_t e;
    dn       = 2 + (bias ? m : 0) + k + m + n + m;
    last     = dn + 2;
    in_reset = 1'b0;
    bus.dim_k_i  = DW'(k - 1);
    bus.dim_m_i  = DW'(m - 1);
    bus.dim_n_i  = DW'(n - 1);
    bus.target_i = TW'(tgt);
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
    bus.bias_en_i = bias[0];
`endif
    bus.start_i = 1'b1;
    check_all(tag, 0, expect_at(0, k, m, n, bias, tgt, prev_tgt));
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start_i = 1'b0;
      rst_n       = 1'b1;
      e = in_reset ? exp_t'('0) : expect_at(c, k, m, n, bias, tgt, prev_tgt);
      check_all(tag, c, e);
      if (c == restart_at) begin
        bus.start_i  = 1'b1;
        bus.dim_k_i  = DW'($urandom);
        bus.dim_m_i  = DW'($urandom);
        bus.dim_n_i  = DW'($urandom);
        bus.target_i = TW'(~tgt);
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
        bus.bias_en_i = ~bias[0];
`endif
      end
      if (c == reset_at) begin
        rst_n    = 1'b0;
        in_reset = 1'b1;
      end
    end
    prev_tgt = in_reset ? 0 : tgt;
  endtask

  initial begin
    int k, m, n, t, b;
    rst_n        = 1'b0;
    bus.start_i  = 1'b1;
    bus.dim_k_i  = DW'($urandom);
    bus.dim_m_i  = DW'($urandom);
    bus.dim_n_i  = DW'($urandom);
    bus.target_i = TW'($urandom);
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
    bus.bias_en_i = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all("reset", i, exp_t'('0));
    end
    rst_n       = 1'b1;
    bus.start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all("post_reset_idle", i, exp_t'('0));
    end

    run_op("op444",    4, 4, 4, 1, 0, -1, -1);
    run_op("op111",    1, 1, 1, 0, 0, -1, -1);
    run_op("restart",  4, 4, 4, 1, 0,  5, -1);
    run_op("rst_feed", 3, 2, 4, 1, 0, -1,  3);
    run_op("after_rst", 2, 3, 1, 1, 0, -1, -1);
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
    run_op("bias222",  2, 2, 2, 1, 1, -1, -1);
    run_op("nobias222", 2, 2, 2, 0, 0, -1, -1);
`endif
    for (int i = 0; i < 6; i++) begin
      k = int'($urandom_range(4, 1));
      m = int'($urandom_range(4, 1));
      n = int'($urandom_range(4, 1));
      t = int'($urandom_range(SP_NTARGETS_DEF - 1, 0));
`ifdef MATMUL_SEQ_CTRL_BIAS_EN
      b = int'($urandom_range(1, 0));
`else
      b = 0;
`endif
      run_op($sformatf("rand%0d", i), k, m, n, t, b, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
